// File: rtl/digit_field_renderer_if.sv
// Load-side port bundle of digit_field_renderer: value handshake plus status.
// A transfer happens on a rising clk edge where value_valid && value_ready; value_in and
// blank_leading are sampled on that edge only, and value_valid is ignored while value_ready is low.
interface digit_field_renderer_if #(
   parameter int VALUE_W = 14
);
   logic [VALUE_W-1:0] value_in;
   logic               value_valid;
   logic               value_ready;
   logic               blank_leading;
   logic               busy;

   modport master (
      output value_in, value_valid, blank_leading,
      input  value_ready, busy
   );

   modport slave (
      input  value_in, value_valid, blank_leading,
      output value_ready, busy
   );
endinterface

// File: rtl/digit_field_renderer.sv
// Right-aligned decimal field overlay: sequential double-dabble conversion committed in one
// cycle to the digit registers, plus a 2-stage pixel lookup into a seven-segment 16x32 font.
module digit_field_renderer #(
   parameter int X0          = 0,
   parameter int Y0          = 0,
   parameter int NUM_DIGITS  = 4,
   parameter int VALUE_W     = 14,
   parameter int SCALE_SHIFT = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [9:0]             x,
   input  logic [9:0]             y,
   digit_field_renderer_if.slave  bus,
   output logic                   on_pixel
);
   localparam int GW    = 16 << SCALE_SHIFT;
   localparam int GH    = 32 << SCALE_SHIFT;
   localparam int FW    = NUM_DIGITS * GW;
   localparam int BW    = 4 * NUM_DIGITS;
   localparam int CW    = $clog2(VALUE_W + 1);
   localparam int LIMIT = 10 ** NUM_DIGITS;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_e;

   state_e                         state_q, state_d;
   logic [CW-1:0]                  cnt_q, cnt_d;
   logic [VALUE_W-1:0]             bin_q, bin_d;
   logic [BW-1:0]                  bcd_q, bcd_d;
   logic                           blank_q, blank_d;
   logic                           ovf_q, ovf_d;
   logic [NUM_DIGITS-1:0][3:0]     digits_q, digits_d;

   logic                           s1_in_q, s1_in_d;
   logic [2:0]                     s1_idx_q, s1_idx_d;
   logic [3:0]                     s1_col_q, s1_col_d;
   logic [4:0]                     s1_row_q, s1_row_d;
   logic                           on_q, on_d;

   // Seven-segment glyphs; code 10 is a dash, anything else above 9 is blank.
   function automatic logic [15:0] glyph_row(input logic [3:0] code, input logic [4:0] row);
      logic [6:0]  seg;
      logic [15:0] w;
      logic        top, upper, lower, bot, mid;
      case (code)
         4'd0:    seg = 7'b1111110;
         4'd1:    seg = 7'b0110000;
         4'd2:    seg = 7'b1101101;
         4'd3:    seg = 7'b1111001;
         4'd4:    seg = 7'b0110011;
         4'd5:    seg = 7'b1011011;
         4'd6:    seg = 7'b1011111;
         4'd7:    seg = 7'b1110000;
         4'd8:    seg = 7'b1111111;
         4'd9:    seg = 7'b1111011;
         default: seg = 7'b0000000;
      endcase
      top   = (row >= 5'd2)  && (row <= 5'd4);
      upper = (row >= 5'd2)  && (row <= 5'd16);
      lower = (row >= 5'd15) && (row <= 5'd29);
      bot   = (row >= 5'd27) && (row <= 5'd29);
      mid   = (row >= 5'd15) && (row <= 5'd16);
      w = 16'h0000;
      if (seg[6] && top)   w = w | 16'h1FF8;
      if (seg[5] && upper) w = w | 16'h001C;
      if (seg[4] && lower) w = w | 16'h001C;
      if (seg[3] && bot)   w = w | 16'h1FF8;
      if (seg[2] && lower) w = w | 16'h3800;
      if (seg[1] && upper) w = w | 16'h3800;
      if (seg[0] && mid)   w = w | 16'h1FF8;
      if (code == 4'd10 && mid) w = 16'h7FFE;
      return w;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (bus.value_valid) state_d = S_SHIFT;
         S_SHIFT:  if (cnt_q == '0) state_d = S_COMMIT;
         S_COMMIT: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.value_ready = (state_q == S_IDLE);
      bus.busy        = (state_q != S_IDLE);
   end

   always_comb begin
      logic [BW-1:0]         adj;
      logic [BW+VALUE_W-1:0] sh;
      logic [3:0]            nib;
      logic                  leading;
      cnt_d    = cnt_q;
      bin_d    = bin_q;
      bcd_d    = bcd_q;
      blank_d  = blank_q;
      ovf_d    = ovf_q;
      digits_d = digits_q;
      adj      = bcd_q;
      sh       = '0;
      nib      = 4'd0;
      leading  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.value_valid) begin
               bin_d   = bus.value_in;
               bcd_d   = '0;
               blank_d = bus.blank_leading;
               ovf_d   = (32'(bus.value_in) >= 32'(LIMIT));
               cnt_d   = CW'(VALUE_W - 1);
            end
         end
         S_SHIFT: begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               nib = bcd_q[4*i +: 4];
               adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
            end
            // Digits above NUM_DIGITS fall off the top; only the overflow case needs them.
            sh = {adj, bin_q} << 1;
            {bcd_d, bin_d} = sh;
            cnt_d = cnt_q - 1'b1;
         end
         S_COMMIT: begin
            leading = blank_q;
            for (int i = 0; i < NUM_DIGITS; i++) begin
               nib = bcd_q[4*(NUM_DIGITS-1-i) +: 4];
               if (ovf_q) begin
                  digits_d[i] = 4'd10;
               end else if (leading && nib == 4'd0 && i != NUM_DIGITS - 1) begin
                  digits_d[i] = 4'd11;
               end else begin
                  digits_d[i] = nib;
                  leading     = 1'b0;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         bin_q    <= '0;
         bcd_q    <= '0;
         blank_q  <= 1'b0;
         ovf_q    <= 1'b0;
         digits_q <= {NUM_DIGITS{4'd11}};
      end else begin
         cnt_q    <= cnt_d;
         bin_q    <= bin_d;
         bcd_q    <= bcd_d;
         blank_q  <= blank_d;
         ovf_q    <= ovf_d;
         digits_q <= digits_d;
      end
   end

   // 11-bit local coordinates: positions left of/above the field wrap to large values and fail the bound.
   always_comb begin
      logic [10:0] lx, ly;
      lx       = {1'b0, x} - 11'(X0);
      ly       = {1'b0, y} - 11'(Y0);
      s1_in_d  = (lx < 11'(FW)) && (ly < 11'(GH));
      s1_idx_d = 3'(lx >> (4 + SCALE_SHIFT));
      s1_col_d = lx[SCALE_SHIFT +: 4];
      s1_row_d = ly[SCALE_SHIFT +: 5];
   end

   always_comb begin
      logic [3:0]  code;
      logic [15:0] row_word;
      code = 4'd11;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (s1_idx_q == 3'(i)) code = digits_q[i];
      end
      row_word = glyph_row(code, s1_row_q);
      on_d     = s1_in_q && row_word[4'd15 - s1_col_q];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_in_q  <= 1'b0;
         s1_idx_q <= 3'd0;
         s1_col_q <= 4'd0;
         s1_row_q <= 5'd0;
         on_q     <= 1'b0;
      end else begin
         s1_in_q  <= s1_in_d;
         s1_idx_q <= s1_idx_d;
         s1_col_q <= s1_col_d;
         s1_row_q <= s1_row_d;
         on_q     <= on_d;
      end
   end

   assign on_pixel = on_q;
endmodule

// File: tb/tb_digit_field_renderer.sv
// Bench for digit_field_renderer: a default instance and a scaled, offset 3-digit instance,
// checked against a decimal/rectangle-based model of the displayed field.
module tb_digit_field_renderer;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [9:0] x = '0;
   logic [9:0] y = '0;
   logic       on0, on1;

   digit_field_renderer_if #(.VALUE_W(14)) if0 ();
   digit_field_renderer_if #(.VALUE_W(10)) if1 ();

   digit_field_renderer u_dut0 (
      .clk(clk), .reset(reset), .x(x), .y(y), .bus(if0.slave), .on_pixel(on0)
   );

   digit_field_renderer #(
      .X0(200), .Y0(100), .NUM_DIGITS(3), .VALUE_W(10), .SCALE_SHIFT(1)
   ) u_dut1 (
      .clk(clk), .reset(reset), .x(x), .y(y), .bus(if1.slave), .on_pixel(on1)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   int x0_p [2] = '{0, 200};
   int y0_p [2] = '{0, 100};
   int nd_p [2] = '{4, 3};
   int ss_p [2] = '{0, 1};
   int m [2][6];

   logic [1:0] exp_q [$];
   int         px_q [$];
   int         py_q [$];

   typedef struct packed {
      logic [19:0] value;
      logic        blank;
      logic [15:0] codes;
   } vec_t;
   vec_t vecs [10];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic bit in_r(input int v, input int lo, input int hi);
      return (v >= lo) && (v <= hi);
   endfunction

   // Font as segment rectangles (col, row inclusive) per the team digit font.
   function automatic bit glyph_lit(input int code, input int col, input int row);
      string s;
      bit    lit = 1'b0;
      if (code == 10) return in_r(row, 15, 16) && in_r(col, 1, 14);
      case (code)
         0: s = "abcdef";
         1: s = "bc";
         2: s = "abdeg";
         3: s = "abcdg";
         4: s = "bcfg";
         5: s = "acdfg";
         6: s = "acdefg";
         7: s = "abc";
         8: s = "abcdefg";
         9: s = "abcdfg";
         default: s = "";
      endcase
      for (int i = 0; i < s.len(); i++) begin
         case (s[i])
            "a": lit |= in_r(row, 2, 4)   && in_r(col, 3, 12);
            "b": lit |= in_r(row, 2, 16)  && in_r(col, 11, 13);
            "c": lit |= in_r(row, 15, 29) && in_r(col, 11, 13);
            "d": lit |= in_r(row, 27, 29) && in_r(col, 3, 12);
            "e": lit |= in_r(row, 15, 29) && in_r(col, 2, 4);
            "f": lit |= in_r(row, 2, 16)  && in_r(col, 2, 4);
            "g": lit |= in_r(row, 15, 16) && in_r(col, 3, 12);
            default: ;
         endcase
      end
      return lit;
   endfunction

   function automatic bit ref_pix(input int d, input int px, input int py);
      int w, h, lx, ly;
      w  = 16 << ss_p[d];
      h  = 32 << ss_p[d];
      lx = px - x0_p[d];
      ly = py - y0_p[d];
      if (lx < 0 || ly < 0 || lx >= nd_p[d] * w || ly >= h) return 1'b0;
      return glyph_lit(m[d][lx / w], (lx % w) >> ss_p[d], ly >> ss_p[d]);
   endfunction

   task automatic model_load(input int d, input int v, input bit blank);
      bit lead = blank;
      int dig;
      for (int i = 0; i < 6; i++) m[d][i] = 11;
      for (int i = 0; i < nd_p[d]; i++) begin
         dig = (v / (10 ** (nd_p[d] - 1 - i))) % 10;
         if (v >= 10 ** nd_p[d])                        m[d][i] = 10;
         else if (lead && dig == 0 && i < nd_p[d] - 1) m[d][i] = 11;
         else begin
            m[d][i] = dig;
            lead    = 1'b0;
         end
      end
   endtask

   task automatic model_blank();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 6; i++) m[d][i] = 11;
   endtask

   task automatic compare_front();
      logic [1:0] e;
      int cx, cy;
      e  = exp_q.pop_front();
      cx = px_q.pop_front();
      cy = py_q.pop_front();
      check($sformatf("pix0 (%0d,%0d)", cx, cy), int'(on0), int'(e[0]));
      check($sformatf("pix1 (%0d,%0d)", cx, cy), int'(on1), int'(e[1]));
   endtask

   // One pixel per clock; the result is due two edges after the coordinate is sampled.
   task automatic step_pix(input int px, input int py);
      @(negedge clk);
      if (exp_q.size() == 2) compare_front();
      x = 10'(px);
      y = 10'(py);
      exp_q.push_back({ref_pix(1, px, py), ref_pix(0, px, py)});
      px_q.push_back(px);
      py_q.push_back(py);
   endtask

   task automatic flush_pix();
      while (exp_q.size() > 0) begin
         @(negedge clk);
         compare_front();
      end
   endtask

   task automatic scan_rect(input int xl, input int xh, input int yl, input int yh, input int stp);
      for (int yy = yl; yy <= yh; yy += stp)
         for (int xx = xl; xx <= xh; xx += stp)
            step_pix(xx, yy);
      flush_pix();
   endtask

   task automatic check_pix(input int d, input int px, input int py, input int exp, input string name);
      @(negedge clk);
      x = 10'(px);
      y = 10'(py);
      repeat (2) @(negedge clk);
      check(name, (d == 0) ? int'(on0) : int'(on1), exp);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((if0.busy || if1.busy) && n < 60) begin
         @(negedge clk);
         n++;
      end
      check(name, int'(n < 60), 1);
   endtask

   task automatic load2(input int v0, input bit b0, input int v1, input bit b1);
      @(negedge clk);
      check("ready0 before load", int'(if0.value_ready), 1);
      check("ready1 before load", int'(if1.value_ready), 1);
      if0.value_valid = 1'b1; if0.value_in = 14'(v0); if0.blank_leading = b0;
      if1.value_valid = 1'b1; if1.value_in = 10'(v1); if1.blank_leading = b1;
      @(negedge clk);
      if0.value_valid = 1'b0; if0.value_in = 14'($urandom); if0.blank_leading = 1'($urandom);
      if1.value_valid = 1'b0; if1.value_in = 10'($urandom); if1.blank_leading = 1'($urandom);
      wait_idle("load timeout");
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d", total);
      $fatal(1, "watchdog");
   end

   initial begin
      int b0, r0, b1, t [2], nr, v0, v1;
      bit bl;

      vecs[0] = '{20'd1234,  1'b0, 16'h1234};
      vecs[1] = '{20'd7,     1'b1, 16'hBBB7};
      vecs[2] = '{20'd7,     1'b0, 16'h0007};
      vecs[3] = '{20'd10000, 1'b0, 16'hAAAA};
      vecs[4] = '{20'd0,     1'b1, 16'hBBB0};
      vecs[5] = '{20'd9999,  1'b1, 16'h9999};
      vecs[6] = '{20'd100,   1'b1, 16'hB100};
      vecs[7] = '{20'd16383, 1'b1, 16'hAAAA};
      vecs[8] = '{20'd10,    1'b1, 16'hBB10};
      vecs[9] = '{20'd5050,  1'b1, 16'h5050};

      if0.value_valid = 1'b0; if0.value_in = '0; if0.blank_leading = 1'b0;
      if1.value_valid = 1'b0; if1.value_in = '0; if1.blank_leading = 1'b0;
      model_blank();

      // Reset and idle status
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset busy0", int'(if0.busy), 0);
      check("reset ready0", int'(if0.value_ready), 1);
      check("reset busy1", int'(if1.busy), 0);
      check("reset ready1", int'(if1.value_ready), 1);
      check("reset on0", int'(on0), 0);

      // Coarse full-frame sweep before any load: nothing lit
      scan_rect(0, 639, 0, 479, 6);
      check("idle busy0 after sweep", int'(if0.busy), 0);

      // Busy/ready window, with a load request injected mid-conversion
      @(negedge clk);
      if0.value_valid = 1'b1; if0.value_in = 14'd1234; if0.blank_leading = 1'b0;
      if1.value_valid = 1'b1; if1.value_in = 10'd1;    if1.blank_leading = 1'b1;
      @(negedge clk);
      if0.value_valid = 1'b0;
      if1.value_valid = 1'b0;
      b0 = 0; r0 = 0; b1 = 0;
      for (int k = 0; k < 40; k++) begin
         if (if0.busy) b0++;
         if (!if0.value_ready) r0++;
         if (if1.busy) b1++;
         if (k == 5) begin
            if0.value_valid = 1'b1; if0.value_in = 14'd5678;
            if1.value_valid = 1'b1; if1.value_in = 10'd999;
         end else begin
            if0.value_valid = 1'b0;
            if1.value_valid = 1'b0;
         end
         @(negedge clk);
      end
      check("busy0 cycles", b0, 15);
      check("ready0 low cycles", r0, 15);
      check("busy1 cycles", b1, 11);
      check("busy0 after window", int'(if0.busy), 0);
      model_load(0, 1234, 1'b0);
      model_load(1, 1, 1'b1);
      check_pix(0, 19, 29, 1, "digit2 row29 col3");
      check_pix(0, 19, 30, 0, "digit2 row30");
      check_pix(0, 64, 5, 0, "right boundary");
      check_pix(0, 1023, 10, 0, "left of field");
      check_pix(1, 286, 104, 1, "x2 corner tl");
      check_pix(1, 287, 104, 1, "x2 corner tr");
      check_pix(1, 286, 105, 1, "x2 corner bl");
      check_pix(1, 287, 105, 1, "x2 corner br");
      check_pix(1, 285, 104, 0, "x2 col left");
      check_pix(1, 286, 103, 0, "x2 row above");
      scan_rect(0, 66, 0, 33, 1);
      scan_rect(196, 300, 96, 166, 2);

      // Table-driven loads, full tile scan of the default instance
      for (int v = 0; v < 10; v++) begin
         load2(int'(vecs[v].value), vecs[v].blank, int'(vecs[v].value) % 1000, vecs[v].blank);
         for (int i = 0; i < 6; i++) m[0][i] = 11;
         for (int i = 0; i < 4; i++) m[0][i] = int'(vecs[v].codes[4*(3-i) +: 4]);
         model_load(1, int'(vecs[v].value) % 1000, vecs[v].blank);
         scan_rect(0, 65, 0, 33, 1);
      end

      // Back-to-back conversions with value_valid held high
      @(negedge clk);
      if0.value_valid = 1'b1; if0.value_in = 14'd42; if0.blank_leading = 1'b0;
      nr = 0; t[0] = -100; t[1] = -100;
      for (int k = 0; k < 40; k++) begin
         if (if0.value_ready && nr < 2) begin
            t[nr] = k;
            nr++;
         end
         @(negedge clk);
      end
      if0.value_valid = 1'b0;
      check("back-to-back spacing", t[1] - t[0], 16);
      wait_idle("b2b timeout");
      model_load(0, 42, 1'b0);
      scan_rect(0, 65, 0, 33, 2);

      // Reset in the middle of a conversion
      @(negedge clk);
      if0.value_valid = 1'b1; if0.value_in = 14'd4321; if0.blank_leading = 1'b0;
      if1.value_valid = 1'b1; if1.value_in = 10'd777;  if1.blank_leading = 1'b0;
      @(negedge clk);
      if0.value_valid = 1'b0;
      if1.value_valid = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("reset mid-shift busy0", int'(if0.busy), 0);
      check("reset mid-shift busy1", int'(if1.busy), 0);
      check("reset mid-shift ready0", int'(if0.value_ready), 1);
      repeat (20) @(negedge clk);
      check("no commit after reset", int'(if0.busy), 0);
      model_blank();
      scan_rect(0, 65, 0, 33, 1);
      scan_rect(196, 300, 96, 166, 2);

      // Randomized loads against the model
      for (int r = 0; r < 15; r++) begin
         case ($urandom_range(0, 2))
            0:       v0 = int'($urandom_range(0, 99));
            1:       v0 = int'($urandom_range(0, 9999));
            default: v0 = int'($urandom_range(0, 16383));
         endcase
         v1 = int'($urandom_range(0, 1023));
         bl = 1'($urandom);
         load2(v0, bl, v1, ~bl);
         model_load(0, v0, bl);
         model_load(1, v1, ~bl);
         for (int p = 0; p < 250; p++)
            step_pix(int'($urandom_range(0, 67)), int'($urandom_range(0, 34)));
         for (int p = 0; p < 250; p++)
            step_pix(int'($urandom_range(197, 299)), int'($urandom_range(97, 166)));
         flush_pix();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
